// File: rtl/hazard_scheduler.sv
// hazard_scheduler: MIPS 5-stage interlock and forwarding control driven by a shadow E/M/W destination pipeline.
module hazard_scheduler #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_valid,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [4:0]       D_wa,
  input  logic [1:0]       T_use_rs,
  input  logic [1:0]       T_use_rt,
  input  logic [1:0]       D_T_new,
  output logic             stall,
  output logic             F_en,
  output logic             D_en,
  output logic             E_clr,
  output logic [1:0]       fwd_D_rs,
  output logic [1:0]       fwd_D_rt,
  output logic [1:0]       fwd_E_rs,
  output logic [1:0]       fwd_E_rt,
  output logic             fwd_M_rt,
  output logic [CNT_W-1:0] stall_cnt
);
  logic       v_e, v_m, v_w;
  logic [4:0] wa_e, rs_e, rt_e, wa_m, rt_m, wa_w;
  logic [1:0] tn_e, tn_m;
  function automatic logic hit(input logic v, input logic [4:0] wa, input logic [4:0] r);
    return v && wa == r && r != 5'd0;
  endfunction
  function automatic logic [1:0] dec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction
  // a nearer stage still computing its result blocks farther stages; the stall covers that case
  function automatic logic [1:0] sel(input logic he, input logic hm, input logic hw,
                                     input logic [1:0] tne, input logic [1:0] tnm);
    return he ? ((tne == 2'd0) ? 2'd1 : 2'd0) :
           hm ? ((tnm == 2'd0) ? 2'd2 : 2'd0) :
           hw ? 2'd3 : 2'd0;
  endfunction
  assign stall = D_valid && ((hit(v_e, wa_e, D_rs) && tn_e > T_use_rs) ||
                             (hit(v_m, wa_m, D_rs) && tn_m > T_use_rs) ||
                             (hit(v_e, wa_e, D_rt) && tn_e > T_use_rt) ||
                             (hit(v_m, wa_m, D_rt) && tn_m > T_use_rt));
  assign F_en  = !stall;
  assign D_en  = !stall;
  assign E_clr = stall;
  assign fwd_D_rs = sel(hit(v_e, wa_e, D_rs), hit(v_m, wa_m, D_rs), hit(v_w, wa_w, D_rs), tn_e, tn_m);
  assign fwd_D_rt = sel(hit(v_e, wa_e, D_rt), hit(v_m, wa_m, D_rt), hit(v_w, wa_w, D_rt), tn_e, tn_m);
  assign fwd_E_rs = sel(1'b0, hit(v_m, wa_m, rs_e), hit(v_w, wa_w, rs_e), tn_e, tn_m);
  assign fwd_E_rt = sel(1'b0, hit(v_m, wa_m, rt_e), hit(v_w, wa_w, rt_e), tn_e, tn_m);
  assign fwd_M_rt = hit(v_w, wa_w, rt_m);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {v_e, wa_e, rs_e, rt_e, tn_e} <= '0;
      {v_m, wa_m, rt_m, tn_m}       <= '0;
      {v_w, wa_w}                   <= '0;
      stall_cnt                     <= '0;
    end else begin
      v_e       <= D_valid && !stall;
      wa_e      <= stall ? 5'd0 : D_wa;
      rs_e      <= stall ? 5'd0 : D_rs;
      rt_e      <= stall ? 5'd0 : D_rt;
      tn_e      <= stall ? 2'd0 : dec(D_T_new);
      v_m       <= v_e;
      wa_m      <= wa_e;
      rt_m      <= rt_e;
      tn_m      <= dec(tn_e);
      v_w       <= v_m;
      wa_w      <= wa_m;
      stall_cnt <= stall_cnt + CNT_W'(stall);
    end
  end
endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed hazard scenarios plus random instruction streams checked against an age-based pipeline model.
module tb_hazard_scheduler;
  logic        clk = 0, reset = 0, D_valid = 0;
  logic [4:0]  D_rs = 0, D_rt = 0, D_wa = 0;
  logic [1:0]  T_use_rs = 3, T_use_rt = 3, D_T_new = 0;
  logic        stall, F_en, D_en, E_clr, fwd_M_rt;
  logic [1:0]  fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
  logic [31:0] stall_cnt;
  int n_cmp = 0, n_bad = 0;

  hazard_scheduler #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt), .D_wa(D_wa),
    .T_use_rs(T_use_rs), .T_use_rt(T_use_rt), .D_T_new(D_T_new),
    .stall(stall), .F_en(F_en), .D_en(D_en), .E_clr(E_clr),
    .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt), .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt),
    .fwd_M_rt(fwd_M_rt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each in-flight instruction keeps its original T_new; at stage k (0=E,1=M,2=W)
  // its result is still max(T_new-1-k, 0) cycles away.
  typedef struct packed {
    logic       v;
    logic [4:0] wa, rs, rt;
    logic [2:0] tn;
  } ent_t;
  ent_t p [3];
  int   m_cnt;

  function automatic int rem(input int k);
    int r = int'(p[k].tn) - 1 - k;
    return r < 0 ? 0 : r;
  endfunction
  function automatic bit hitm(input int k, input logic [4:0] r);
    return p[k].v && p[k].wa == r && r != 5'd0;
  endfunction
  function automatic bit m_stall();
    bit s = 0;
    for (int k = 0; k < 2; k++)
      s |= (hitm(k, D_rs) && rem(k) > int'(T_use_rs)) || (hitm(k, D_rt) && rem(k) > int'(T_use_rt));
    return D_valid && s;
  endfunction
  function automatic logic [1:0] m_fwd(input logic [4:0] r, input int first);
    for (int k = first; k < 3; k++)
      if (hitm(k, r)) return rem(k) == 0 ? 2'(k + 1) : 2'd0;
    return 2'd0;
  endfunction
  function automatic void m_clear();
    for (int k = 0; k < 3; k++) p[k] = '0;
    m_cnt = 0;
  endfunction
  function automatic void m_advance();
    bit s = m_stall();
    m_cnt += int'(s);
    p[2] = p[1];
    p[1] = p[0];
    p[0] = s ? '0 : ent_t'{D_valid, D_wa, D_rs, D_rt, {1'b0, D_T_new}};
  endfunction

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                      input logic [1:0] tur, input logic [1:0] tut, input logic [1:0] tn,
                      output bit s, output logic [1:0] fd);
    @(negedge clk);
    D_valid = v; D_rs = rs; D_rt = rt; D_wa = wa; T_use_rs = tur; T_use_rt = tut; D_T_new = tn;
    #1;
    s = m_stall();
    check("stall", stall, s);
    check("F_en", F_en, !s);
    check("D_en", D_en, !s);
    check("E_clr", E_clr, s);
    check("fwd_D_rs", fwd_D_rs, m_fwd(D_rs, 0));
    check("fwd_D_rt", fwd_D_rt, m_fwd(D_rt, 0));
    check("fwd_E_rs", fwd_E_rs, m_fwd(p[0].rs, 1));
    check("fwd_E_rt", fwd_E_rt, m_fwd(p[0].rt, 1));
    check("fwd_M_rt", fwd_M_rt, hitm(2, p[1].rt));
    check("stall_cnt", stall_cnt, m_cnt);
    fd = fwd_D_rs;
    @(posedge clk);
    m_advance();
  endtask

  // Presents one instruction, holding it in D while the interlock is active.
  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                       input logic [1:0] tur, input logic [1:0] tut, input logic [1:0] tn,
                       output int ns, output logic [1:0] fd);
    bit s;
    ns = 0;
    for (int i = 0; i < 4; i++) begin
      step(v, rs, rt, wa, tur, tut, tn, s, fd);
      if (!s) return;
      ns++;
    end
    check("stall_bound", ns, 2);
  endtask

  initial begin
    int ns;
    logic [1:0] fd;
    bit s;
    logic v;
    logic [4:0] rs, rt, wa;
    logic [1:0] tur, tut, tn;
    m_clear();
    #3;
    check("rst_stall", stall, 0);
    check("rst_F_en", F_en, 1);
    check("rst_E_clr", E_clr, 0);
    check("rst_fwd", {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt}, 0);
    check("rst_cnt", stall_cnt, 0);
    #4 reset = 1;
    // lw $8 then add using $8 one cycle later
    issue(1, 2, 0, 8, 1, 3, 3, ns, fd);
    issue(1, 8, 3, 11, 1, 1, 2, ns, fd);
    check("s1_stalls", ns, 1);
    #1;
    check("s1_fwdE", fwd_E_rs, 3);
    check("s1_cnt", stall_cnt, 1);
    // add $9 then beq on $9
    issue(1, 1, 2, 9, 1, 1, 2, ns, fd);
    issue(1, 9, 0, 0, 0, 0, 0, ns, fd);
    check("s2_stalls", ns, 1);
    check("s2_fwdD", fd, 2);
    // lw $10 then sw storing $10
    issue(1, 3, 0, 10, 1, 3, 3, ns, fd);
    issue(1, 4, 10, 0, 1, 2, 0, ns, fd);
    check("s3_stalls", ns, 0);
    issue(0, 0, 0, 0, 3, 3, 0, ns, fd);
    #1;
    check("s3_fwdM", fwd_M_rt, 1);
    // jal then jr $31
    issue(1, 0, 0, 31, 3, 3, 1, ns, fd);
    issue(1, 31, 0, 0, 0, 3, 0, ns, fd);
    check("s4_stalls", ns, 0);
    check("s4_fwdD", fd, 1);
    // writers of $0 never interlock or forward
    issue(1, 1, 2, 0, 1, 1, 2, ns, fd);
    issue(1, 0, 0, 0, 1, 3, 3, ns, fd);
    issue(1, 0, 0, 7, 0, 0, 2, ns, fd);
    check("s5_stalls", ns, 0);
    check("s5_fwdD", fd, 0);
    // back-to-back writers of $5: nearer one wins
    issue(1, 1, 1, 5, 1, 1, 1, ns, fd);
    issue(1, 2, 2, 5, 1, 1, 1, ns, fd);
    issue(1, 5, 0, 0, 0, 3, 0, ns, fd);
    check("s5b_fwdD", fd, 1);
    // reset asserted in the middle of a lw-use stall
    issue(1, 2, 0, 8, 1, 3, 3, ns, fd);
    @(negedge clk);
    D_valid = 1; D_rs = 8; D_rt = 0; D_wa = 12; T_use_rs = 1; T_use_rt = 3; D_T_new = 2;
    #1;
    check("s6_pre_stall", stall, 1);
    reset = 0;
    #1;
    m_clear();
    check("s6_stall", stall, 0);
    check("s6_cnt", stall_cnt, 0);
    check("s6_en", {F_en, D_en, E_clr}, 3'b110);
    D_valid = 0; D_rs = 0; D_rt = 0; D_wa = 0; T_use_rs = 3; T_use_rt = 3; D_T_new = 0;
    #1 reset = 1;
    @(posedge clk);
    m_advance();
    issue(1, 6, 7, 13, 1, 1, 2, ns, fd);
    check("s6_post_stalls", ns, 0);
    // random instruction stream over a small register set to provoke hazards
    s = 0;
    {v, rs, rt, wa, tur, tut, tn} = '0;
    for (int i = 0; i < 400; i++) begin
      if (!s) begin
        v   = ($urandom_range(0, 9) != 0);
        rs  = 5'($urandom_range(0, 4));
        rt  = 5'($urandom_range(0, 4));
        wa  = 5'($urandom_range(0, 4));
        tur = 2'($urandom_range(0, 3));
        tut = 2'($urandom_range(0, 3));
        tn  = 2'($urandom_range(0, 3));
      end
      step(v, rs, rt, wa, tur, tut, tn, s, fd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
